// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (I) and data (D) ports of the core.
// A request is accepted when x_ready pulses; exactly one x_rvalid pulse later returns its response.
module mem_port_arbiter #(
   parameter int WORD_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_req,
   input  logic [WORD_LEN-1:0] i_addr,
   output logic                i_ready,
   output logic                i_rvalid,
   output logic [WORD_LEN-1:0] i_rdata,
   input  logic                d_req,
   input  logic [WORD_LEN-1:0] d_addr,
   input  logic                d_wen,
   input  logic [WORD_LEN-1:0] d_wdata,
   output logic                d_ready,
   output logic                d_rvalid,
   output logic [WORD_LEN-1:0] d_rdata,
   output logic                mem_valid,
   output logic [WORD_LEN-1:0] mem_addr,
   output logic                mem_wen,
   output logic [WORD_LEN-1:0] mem_wdata,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [WORD_LEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic                owner_d;
   logic                last_d;
   logic                win_d;
   logic                accept;
   logic                wen_q;
   logic [WORD_LEN-1:0] addr_q;
   logic [WORD_LEN-1:0] wdata_q;
   logic [WORD_LEN-1:0] i_rdata_q;
   logic [WORD_LEN-1:0] d_rdata_q;

   // On a conflict the port that did not win last time gets the memory.
   always_comb begin
      win_d = 1'b0;
      if (i_req && d_req) begin
         win_d = !last_d;
      end else begin
         win_d = d_req;
      end
   end

   assign accept  = (state == IDLE) && (i_req || d_req);
   assign i_ready = accept && !win_d && rst_n;
   assign d_ready = accept && win_d && rst_n;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_req || d_req) state_nxt = ISSUE;
         ISSUE:   if (mem_ready)      state_nxt = WAIT;
         WAIT:    if (mem_rvalid)     state_nxt = RESP;
         RESP:                        state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner_d   <= 1'b0;
         last_d    <= 1'b1;
         addr_q    <= '0;
         wen_q     <= 1'b0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            owner_d <= win_d;
            last_d  <= win_d;
            addr_q  <= win_d ? d_addr : i_addr;
            wen_q   <= win_d && d_wen;
            wdata_q <= win_d ? d_wdata : '0;
         end
         // Only the owner's data register moves; the other port keeps its last response.
         if ((state == WAIT) && mem_rvalid) begin
            if (owner_d) begin
               d_rdata_q <= wen_q ? '0 : mem_rdata;
            end else begin
               i_rdata_q <= wen_q ? '0 : mem_rdata;
            end
         end
      end
   end

   assign mem_valid = (state == ISSUE);
   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;

   assign i_rvalid  = (state == RESP) && !owner_d;
   assign d_rvalid  = (state == RESP) && owner_d;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule
